vect_iter_div: RTL and testbench

- Multi-cycle iterative integer divider/remainder unit for the vector lane.
- Replaces the single-cycle combinational divide path in the lane ALU, which is too slow for timing closure.
- Parametrised in data width and in quotient bits retired per cycle (radix).
- Implements RISC-V V divide semantics, including divide-by-zero and signed overflow.
- Uses a valid/ready handshake on both sides, so the lane sequencer can stall on it.

---
 rtl/vect_iter_div_if.sv | 36 +++
 rtl/vect_iter_div.sv | 143 ++++++++++++++
 tb/tb_vect_iter_div.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vect_iter_div_if.sv
// Request/response bundle for the iterative vector-lane divider.
// Signal names match the divider's original flat port list so that lane code
// written against those names keeps reading the same.
//   Request : valid_i/ready_o handshake, mask_en_i, signed_i, rem_i,
//             dividend_i (vs2), divisor_i (vs1), flush_i (synchronous abort)
//   Response: valid_o/ready_i handshake, result_o, div_zero_o
// slave  : the divider side.
// master : the lane sequencer side.
interface vect_iter_div_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_i;
  logic                  ready_o;
  logic                  mask_en_i;
  logic                  signed_i;
  logic                  rem_i;
  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisor_i;
  logic                  flush_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  div_zero_o;

  modport slave (
    input  valid_i, mask_en_i, signed_i, rem_i, dividend_i, divisor_i,
           flush_i, ready_i,
    output ready_o, valid_o, result_o, div_zero_o
  );

  modport master (
    output valid_i, mask_en_i, signed_i, rem_i, dividend_i, divisor_i,
           flush_i, ready_i,
    input  ready_o, valid_o, result_o, div_zero_o
  );
endinterface

// File: rtl/vect_iter_div.sv
// Multi-cycle iterative integer divider/remainder for the vector lane
// (RISC-V V VDIV/VDIVU/VREM/VREMU semantics).
// Restoring shift-subtract on operand magnitudes, BITS_PER_CYCLE quotient
// bits per CALC cycle, sign fix-up folded into the last CALC edge.
// Ports:
//   clk_i     : clock, rising edge
//   resetn_i  : asynchronous active-low reset
//   bus       : vect_iter_div_if.slave (request/response handshakes, operands,
//               flush, result and divide-by-zero flag)
// Masked-off elements, divide-by-zero and signed overflow are resolved at
// accept and go straight to DONE (valid_o the cycle after accept).
module vect_iter_div #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  vect_iter_div_if.slave bus
);

  localparam int unsigned ITER  = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH:0]   rem_q;      // partial remainder, one guard bit
  logic [DATA_WIDTH-1:0] quo_q;      // dividend shifts out as quotient shifts in
  logic [DATA_WIDTH-1:0] dvs_q;      // divisor magnitude
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic                  rem_sel_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  div_zero_q;

  logic                  accept;
  logic                  is_div_zero;
  logic                  is_ovf;
  logic                  is_special;
  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   rem_step;
  logic [DATA_WIDTH-1:0] quo_step;
  logic [DATA_WIDTH-1:0] quo_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  // Request decode and operand magnitudes.
  always_comb begin
    accept      = bus.valid_i && (state_q == IDLE) && !bus.flush_i;
    is_div_zero = (bus.divisor_i == '0);
    is_ovf      = bus.signed_i && (bus.dividend_i == MOST_NEG) && (bus.divisor_i == '1);
    is_special  = !bus.mask_en_i || is_div_zero || is_ovf;
    a_neg       = bus.signed_i && bus.dividend_i[DATA_WIDTH-1];
    b_neg       = bus.signed_i && bus.divisor_i[DATA_WIDTH-1];
    a_mag       = a_neg ? -bus.dividend_i : bus.dividend_i;
    b_mag       = b_neg ? -bus.divisor_i  : bus.divisor_i;
  end

  // BITS_PER_CYCLE chained restoring steps per cycle.
  always_comb begin
    rem_step = rem_q;
    quo_step = quo_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_step = {rem_step[DATA_WIDTH-1:0], quo_step[DATA_WIDTH-1]};
      quo_step = {quo_step[DATA_WIDTH-2:0], 1'b0};
      if (rem_step >= {1'b0, dvs_q}) begin
        rem_step    = rem_step - {1'b0, dvs_q};
        quo_step[0] = 1'b1;
      end
    end
    quo_fix = neg_quo_q ? -quo_step : quo_step;
    rem_fix = neg_rem_q ? -rem_step[DATA_WIDTH-1:0] : rem_step[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.valid_i) state_d = is_special ? DONE : CALC;
        CALC:    if (cnt_q == CNT_LAST) state_d = DONE;
        DONE:    if (bus.ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= a_mag;
      dvs_q      <= b_mag;
      neg_quo_q  <= a_neg ^ b_neg;
      neg_rem_q  <= a_neg;
      rem_sel_q  <= bus.rem_i;
      div_zero_q <= 1'b0;
      if (!bus.mask_en_i) begin
        result_q <= '0;
      end else if (is_div_zero) begin
        result_q   <= bus.rem_i ? bus.dividend_i : '1;
        div_zero_q <= 1'b1;
      end else if (is_ovf) begin
        result_q <= bus.rem_i ? '0 : bus.dividend_i;
      end
    end else if ((state_q == CALC) && !bus.flush_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
      rem_q <= rem_step;
      quo_q <= quo_step;
      if (cnt_q == CNT_LAST) result_q <= rem_sel_q ? rem_fix : quo_fix;
    end
  end

  assign bus.ready_o    = (state_q == IDLE);
  assign bus.valid_o    = (state_q == DONE);
  assign bus.result_o   = result_q;
  assign bus.div_zero_o = div_zero_q;

endmodule

// File: tb/tb_vect_iter_div.sv
// Directed + randomised bench for vect_iter_div: a radix-2 build (u1) and a
// radix-16 build (u4) checked against a plain-arithmetic reference model.
module tb_vect_iter_div;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst1_n, rst4_n;
  int   checks   = 0;
  int   failures = 0;
  logic [W:0] q1[$];   // {div_zero, result} expected from u1
  logic [W:0] q4[$];

  vect_iter_div_if #(.DATA_WIDTH(W)) bus1 ();
  vect_iter_div_if #(.DATA_WIDTH(W)) bus4 ();

  vect_iter_div #(.DATA_WIDTH(W), .BITS_PER_CYCLE(1)) u1 (
    .clk_i(clk), .resetn_i(rst1_n), .bus(bus1.slave));
  vect_iter_div #(.DATA_WIDTH(W), .BITS_PER_CYCLE(4)) u4 (
    .clk_i(clk), .resetn_i(rst4_n), .bus(bus4.slave));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Reference: RISC-V V divide rules in plain arithmetic.
  function automatic logic [W:0] model(input logic m, input logic s, input logic r,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    if (!m) return '0;
    if (b == 0) return {1'b1, (r ? a : 32'hFFFF_FFFF)};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, (r ? 32'h0 : a)};
      sa = a;
      sb = b;
      return {1'b0, (r ? W'(sa % sb) : W'(sa / sb))};
    end
    return {1'b0, (r ? a % b : a / b)};
  endfunction

  function automatic int lat_of(input logic m, input logic s,
                                input logic [W-1:0] a, input logic [W-1:0] b, input int iter);
    if (!m || b == 0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
    return iter;
  endfunction

  // Single compare process: every cycle a result is presented it must equal
  // the oldest outstanding expectation; results with nothing outstanding fail.
  always @(negedge clk) begin
    if (rst1_n && bus1.valid_o) begin
      if (q1.size() == 0) chk("u1_spurious_valid", bus1.valid_o, 0);
      else begin
        chk("u1_result", bus1.result_o, q1[0][W-1:0]);
        chk("u1_div_zero", bus1.div_zero_o, q1[0][W]);
        if (bus1.ready_i) void'(q1.pop_front());
      end
    end
    if (rst4_n && bus4.valid_o) begin
      if (q4.size() == 0) chk("u4_spurious_valid", bus4.valid_o, 0);
      else begin
        chk("u4_result", bus4.result_o, q4[0][W-1:0]);
        chk("u4_div_zero", bus4.div_zero_o, q4[0][W]);
        if (bus4.ready_i) void'(q4.pop_front());
      end
    end
  end

  // Called at posedge+1 with u1 idle. hold>0 stalls the result for hold
  // cycles while a stray request is presented.
  task automatic op1(input logic pin, input logic m, input logic s, input logic r,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W:0] exp, input int lat_exp, input int hold);
    int lat;
    if (pin) chk("model_pin", model(m, s, r, a, b), exp);
    bus1.mask_en_i  = m;
    bus1.signed_i   = s;
    bus1.rem_i      = r;
    bus1.dividend_i = a;
    bus1.divisor_i  = b;
    bus1.valid_i    = 1'b1;
    bus1.ready_i    = (hold == 0);
    chk("u1_ready_idle", bus1.ready_o, 1);
    @(posedge clk);
    q1.push_back(exp);
    #1;
    bus1.valid_i    = 1'b0;
    bus1.dividend_i = '1;
    bus1.divisor_i  = 32'd5;
    lat = 0;
    while (!bus1.valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("u1_latency", lat, lat_exp);
    if (hold > 0) begin
      bus1.valid_i   = 1'b1;
      bus1.mask_en_i = 1'b1;
      bus1.divisor_i = '0;
      for (int i = 0; i < hold; i++) begin
        chk("u1_bp_ready", bus1.ready_o, 0);
        chk("u1_bp_valid", bus1.valid_o, 1);
        @(posedge clk); #1;
      end
      bus1.valid_i = 1'b0;
      bus1.ready_i = 1'b1;
    end
    @(posedge clk); #1;
    chk("u1_idle_ready", bus1.ready_o, 1);
    chk("u1_idle_valid", bus1.valid_o, 0);
    chk("u1_drained", q1.size(), 0);
  endtask

  task automatic op4(input logic pin, input logic m, input logic s, input logic r,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W:0] exp, input int lat_exp);
    int lat;
    if (pin) chk("model_pin", model(m, s, r, a, b), exp);
    bus4.mask_en_i  = m;
    bus4.signed_i   = s;
    bus4.rem_i      = r;
    bus4.dividend_i = a;
    bus4.divisor_i  = b;
    bus4.valid_i    = 1'b1;
    chk("u4_ready_idle", bus4.ready_o, 1);
    @(posedge clk);
    q4.push_back(exp);
    #1;
    bus4.valid_i = 1'b0;
    bus4.divisor_i = '1;
    lat = 0;
    while (!bus4.valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("u4_latency", lat, lat_exp);
    @(posedge clk); #1;
    chk("u4_idle_ready", bus4.ready_o, 1);
    chk("u4_drained", q4.size(), 0);
  endtask

  task automatic rand_ops(input bit use4, input int n);
    logic m, s, r;
    logic [W-1:0] a, b;
    for (int k = 0; k < n; k++) begin
      m = ($urandom_range(0, 9) != 0);
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = '1;
        3: begin a = 32'h8000_0000; b = '1; end
        4: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (use4) op4(1'b0, m, s, r, a, b, model(m, s, r, a, b), lat_of(m, s, a, b, 8));
      else      op1(1'b0, m, s, r, a, b, model(m, s, r, a, b), lat_of(m, s, a, b, 32), 0);
    end
  endtask

  initial begin
    int seen;
    rst1_n = 1'b0;
    rst4_n = 1'b0;
    bus1.valid_i = 0; bus1.mask_en_i = 0; bus1.signed_i = 0; bus1.rem_i = 0;
    bus1.dividend_i = '0; bus1.divisor_i = '0; bus1.flush_i = 0; bus1.ready_i = 1;
    bus4.valid_i = 0; bus4.mask_en_i = 0; bus4.signed_i = 0; bus4.rem_i = 0;
    bus4.dividend_i = '0; bus4.divisor_i = '0; bus4.flush_i = 0; bus4.ready_i = 1;
    #13;
    chk("rst_valid", bus1.valid_o, 0);
    chk("rst_result", bus1.result_o, 0);
    chk("rst_div_zero", bus1.div_zero_o, 0);
    chk("rst_valid4", bus4.valid_o, 0);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", bus1.ready_o, 1);

    // Directed vectors on the radix-2 build (ITER=32).
    op1(1, 1, 0, 0, 32'd100,        32'd7,          {1'b0, 32'd14},         32, 0);
    op1(1, 1, 0, 1, 32'd100,        32'd7,          {1'b0, 32'd2},          32, 0);
    op1(1, 1, 1, 0, 32'hFFFF_FFF9,  32'd2,          {1'b0, 32'hFFFF_FFFD},  32, 0);
    op1(1, 1, 1, 1, 32'hFFFF_FFF9,  32'd2,          {1'b0, 32'hFFFF_FFFF},  32, 0);
    op1(1, 1, 1, 0, 32'd7,          32'hFFFF_FFFE,  {1'b0, 32'hFFFF_FFFD},  32, 0);
    op1(1, 1, 1, 1, 32'd7,          32'hFFFF_FFFE,  {1'b0, 32'd1},          32, 0);
    op1(1, 1, 0, 0, 32'h1234,       32'd0,          {1'b1, 32'hFFFF_FFFF},  0,  0);
    op1(1, 1, 1, 1, 32'h1234,       32'd0,          {1'b1, 32'h1234},       0,  0);
    op1(1, 1, 1, 0, 32'h8000_0000,  32'hFFFF_FFFF,  {1'b0, 32'h8000_0000},  0,  0);
    op1(1, 1, 1, 1, 32'h8000_0000,  32'hFFFF_FFFF,  {1'b0, 32'h0},          0,  0);
    op1(1, 1, 0, 0, 32'h8000_0000,  32'hFFFF_FFFF,  {1'b0, 32'h0},          32, 0);
    op1(1, 1, 0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  {1'b0, 32'h8000_0000},  32, 0);
    op1(1, 0, 1, 0, 32'd55,         32'd5,          {1'b0, 32'h0},          0,  0);
    op1(1, 1, 0, 0, 32'd1000,       32'd3,          {1'b0, 32'd333},        32, 5);

    // Flush at CALC cycle 10; a request presented with flush high is ignored.
    bus1.mask_en_i = 1; bus1.signed_i = 0; bus1.rem_i = 0;
    bus1.dividend_i = 32'd100; bus1.divisor_i = 32'd7; bus1.valid_i = 1;
    @(posedge clk); #1;
    bus1.valid_i = 0;
    repeat (10) begin @(posedge clk); #1; end
    bus1.flush_i = 1;
    @(posedge clk); #1;
    chk("flush_ready", bus1.ready_o, 1);
    chk("flush_valid", bus1.valid_o, 0);
    bus1.valid_i = 1;
    @(posedge clk); #1;
    chk("flush_no_accept", bus1.ready_o, 1);
    bus1.flush_i = 0;
    bus1.valid_i = 0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus1.valid_o) seen++; end
    chk("flush_never_valid", seen, 0);

    // Async reset mid-CALC (previous result_o is nonzero).
    op1(1, 1, 0, 1, 32'd1000,       32'd7,          {1'b0, 32'd6},          32, 0);
    bus1.mask_en_i = 1; bus1.dividend_i = 32'd100; bus1.divisor_i = 32'd7; bus1.valid_i = 1;
    @(posedge clk); #1;
    bus1.valid_i = 0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst1_n = 1'b0;
    #1;
    chk("amid_rst_valid", bus1.valid_o, 0);
    chk("amid_rst_result", bus1.result_o, 0);
    chk("amid_rst_div_zero", bus1.div_zero_o, 0);
    @(posedge clk); #1;
    rst1_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus1.valid_o) seen++; end
    chk("rst_never_valid", seen, 0);
    chk("rst_ready_after", bus1.ready_o, 1);

    rand_ops(1'b0, 60);

    // Radix-16 build (ITER=8).
    op4(1, 1, 0, 0, 32'd100,        32'd7,          {1'b0, 32'd14},         8);
    op4(1, 1, 1, 1, 32'hFFFF_FFF9,  32'd2,          {1'b0, 32'hFFFF_FFFF},  8);
    op4(1, 0, 0, 0, 32'd100,        32'd7,          {1'b0, 32'h0},          0);
    op4(1, 1, 0, 0, 32'h1234,       32'd0,          {1'b1, 32'hFFFF_FFFF},  0);
    rand_ops(1'b1, 1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
